// File: rtl/pc_fetch_unit.sv
// PC register and fetch sequencer: BOOT -> REQ/HOLD, with req/ready imem handshake and redirects.
// Optional MISALIGN_TRAP_EN: misaligned redirect targets are rejected and flagged instead of masked.
module pc_fetch_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic            I_clk,
    input  logic            I_rst_n,
    input  logic            I_stall,
    input  logic            I_redirect,
    input  logic [XLEN-1:0] I_redirect_pc,
    input  logic [XLEN-1:0] I_seq_pc,
    input  logic            I_imem_ready,
    output logic [XLEN-1:0] O_pc,
    output logic            O_imem_req,
    output logic            O_fetch_valid,
    output logic [XLEN-1:0] O_fetch_pc,
    output logic            O_misaligned
);

    typedef enum logic [1:0] {BOOT, REQ, HOLD} state_t;

    state_t          state, state_nxt;
    logic [XLEN-1:0] pc, pc_nxt;
    logic [XLEN-1:0] fetch_pc, fetch_pc_nxt;
    logic            fetch_valid, fetch_valid_nxt;
    logic [XLEN-1:0] target;
    logic            redirect_ok;
    logic            fire;

`ifdef MISALIGN_TRAP_EN
    logic target_bad;
    logic misaligned;

    assign target_bad  = |I_redirect_pc[1:0];
    assign target      = I_redirect_pc;
    assign redirect_ok = I_redirect & ~target_bad;

    // A rejected redirect leaves the FSM behaving as if no redirect arrived.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) misaligned <= 1'b0;
        else          misaligned <= I_redirect & target_bad;
    end
    assign O_misaligned = misaligned;
`else
    logic unused_target_lsb;

    assign unused_target_lsb = ^I_redirect_pc[1:0];
    assign target            = {I_redirect_pc[XLEN-1:2], 2'b00};
    assign redirect_ok       = I_redirect;
    assign O_misaligned      = 1'b0;
`endif

    assign fire = (state == REQ) & I_imem_ready;

    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc;
        fetch_pc_nxt    = fetch_pc;
        fetch_valid_nxt = 1'b0;
        if (redirect_ok) pc_nxt = target;
        case (state)
            BOOT: state_nxt = REQ;
            REQ: begin
                // Redirect outranks stall for the PC; stall outranks fire for the state.
                if (I_stall) begin
                    state_nxt = HOLD;
                end else if (!redirect_ok && fire) begin
                    pc_nxt          = I_seq_pc;
                    fetch_pc_nxt    = pc;
                    fetch_valid_nxt = 1'b1;
                end
            end
            HOLD: if (!I_stall) state_nxt = REQ;
            default: state_nxt = BOOT;
        endcase
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state       <= BOOT;
            pc          <= RESET_VECTOR;
            fetch_pc    <= '0;
            fetch_valid <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            fetch_pc    <= fetch_pc_nxt;
            fetch_valid <= fetch_valid_nxt;
        end
    end

    assign O_pc          = pc;
    assign O_imem_req    = (state == REQ);
    assign O_fetch_valid = fetch_valid;
    assign O_fetch_pc    = fetch_pc;

endmodule
